// File: rtl/seg_scan_reader_pkg.sv
// Shared types and constants for the scanned 7-segment display reader.
// Holds the hex glyph table, the segment bit order and the anode polarity helper.
package seg_scan_reader_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int DIG_N = 4;
  localparam int NIB_W = 4;

  typedef logic [SEG_G:SEG_A]  seg_t;
  typedef logic [NIB_W-1:0]    nib_t;
  typedef logic [DIG_N-1:0]    sel_t;

  // Index i holds the glyph for hex digit i, bit0=a .. bit6=g, 1 = lit
  localparam seg_t SEG_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Normalise the anode bus to active-high digit selects
  function automatic sel_t an_to_sel(input sel_t an, input bit active_low);
    return active_low ? ~an : an;
  endfunction
endpackage

// File: rtl/seg_scan_reader_if.sv
// Sample-side and result-side signals of the display reader.
interface seg_scan_reader_if;
  import seg_scan_reader_pkg::*;
  logic        sample_en;
  seg_t        seg;
  sel_t        an;
  logic [15:0] value;
  logic        frame_valid;
  sel_t        digit_err;
  logic [7:0]  bad_sel_cnt;

  modport master (output sample_en, seg, an,
                  input  value, frame_valid, digit_err, bad_sel_cnt);
  modport slave  (input  sample_en, seg, an,
                  output value, frame_valid, digit_err, bad_sel_cnt);
endinterface

// File: rtl/seg_scan_reader_seg_to_hex.sv
// Combinational glyph decoder: segment pattern to nibble plus legality flag.
module seg_to_hex
  import seg_scan_reader_pkg::*;
(
  input  seg_t seg,
  output nib_t nib,
  output logic legal
);
  always_comb begin
    nib   = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_LUT[i]) begin
        nib   = nib_t'(i);
        legal = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_scan_reader.sv
// Recovers a 4-digit hex value from a multiplexed 7-segment drive by debouncing
// each digit and publishing a frame once all four digits have committed.
module seg_scan_reader
  import seg_scan_reader_pkg::*;
#(
  parameter int STABLE_CNT    = 3,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  seg_scan_reader_if.slave bus
);
  localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT - 1);

  seg_t        last_pat [DIG_N];
  logic [3:0]  run_cnt  [DIG_N];
  sel_t        primed;
  logic [15:0] stage, value;
  sel_t        mask, err, mask_nxt;
  logic [7:0]  bad;
  logic        fv;

  sel_t        sel;
  logic        one_hot, hit, same, commit, publish, legal;
  logic [1:0]  dig;
  nib_t        nib;

  seg_to_hex u_dec (.seg(bus.seg), .nib(nib), .legal(legal));

  always_comb begin
    sel     = an_to_sel(bus.an, AN_ACTIVE_LOW);
    one_hot = (sel != '0) && ((sel & (sel - 4'd1)) == '0);
    dig     = '0;
    for (int i = 0; i < DIG_N; i++)
      if (sel[i]) dig = 2'(i);
    hit     = bus.sample_en && one_hot;
    // primed keeps the first sample after reset from matching the cleared pattern
    same    = primed[dig] && (bus.seg == last_pat[dig]);
    commit  = hit && same && (run_cnt[dig] == RUN_MAX - 4'd1);
    publish = (mask == 4'hF);
    mask_nxt = publish ? '0 : mask;
    if (commit && legal) mask_nxt[dig] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage  <= '0;
      value  <= '0;
      mask   <= '0;
      err    <= '0;
      bad    <= '0;
      fv     <= 1'b0;
      primed <= '0;
      for (int i = 0; i < DIG_N; i++) begin
        last_pat[i] <= '0;
        run_cnt[i]  <= '0;
      end
    end else begin
      fv   <= publish;
      mask <= mask_nxt;
      // stage is read before this edge's commit lands, so a same-cycle commit waits a frame
      if (publish) value <= stage;
      if (bus.sample_en && !one_hot && bad != 8'hFF) bad <= bad + 8'd1;
      if (hit) begin
        if (same) begin
          if (run_cnt[dig] != RUN_MAX) run_cnt[dig] <= run_cnt[dig] + 4'd1;
        end else begin
          last_pat[dig] <= bus.seg;
          run_cnt[dig]  <= '0;
          primed[dig]   <= 1'b1;
        end
      end
      if (commit) begin
        err[dig] <= ~legal;
        if (legal) stage[{dig, 2'b00} +: 4] <= nib;
      end
    end
  end

  assign bus.value       = value;
  assign bus.frame_valid = fv;
  assign bus.digit_err   = err;
  assign bus.bad_sel_cnt = bad;
endmodule
